// File: rtl/store_queue.sv
// Circular store queue: speculative alloc, in-order commit, drain to memory.
// Optional STQ_ALLOC_BYPASS_EN forwards the accepted alloc in the same cycle.
module store_queue #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic [ADDR_W-1:0]            alloc_addr,
  input  logic [DATA_W-1:0]            alloc_data,
  output logic                         alloc_ready,
  input  logic [$clog2(COMMIT_W+1)-1:0] commit_count,
  input  logic [ADDR_W-1:0]            search_addr,
  output logic                         search_hit,
  output logic [DATA_W-1:0]            search_data,
  output logic                         mem_valid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  input  logic                         mem_ready,
  output logic [PTR_W:0]               occupancy
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_SPEC = 2'd1;
  localparam logic [1:0] S_CMT  = 2'd2;

  logic [1:0]        state_q [DEPTH];
  logic [1:0]        state_n [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [PTR_W:0]   head_q, cmt_q, tail_q;
  logic [PTR_W:0]   head_n, cmt_n, tail_n;
  logic [PTR_W:0]   spec_cnt, n_cmt;
  logic [PTR_W-1:0] head_i, cmt_i, tail_i;
  logic             do_alloc, do_drain;

  assign head_i = head_q[PTR_W-1:0];
  assign cmt_i  = cmt_q[PTR_W-1:0];
  assign tail_i = tail_q[PTR_W-1:0];

  assign occupancy   = tail_q - head_q;
  assign alloc_ready = occupancy != (PTR_W+1)'(DEPTH);
  assign mem_valid   = state_q[head_i] == S_CMT;
  assign mem_addr    = addr_q[head_i];
  assign mem_data    = data_q[head_i];

  assign do_alloc = alloc_valid & alloc_ready & ~flush;
  assign do_drain = mem_valid & mem_ready;
  assign spec_cnt = tail_q - cmt_q;

  always_comb begin
    n_cmt = (PTR_W+1)'(commit_count);
    if (n_cmt > (PTR_W+1)'(COMMIT_W)) n_cmt = (PTR_W+1)'(COMMIT_W);
    if (n_cmt > spec_cnt) n_cmt = spec_cnt;

    state_n = state_q;
    for (int i = 0; i < COMMIT_W; i++) begin
      if ((PTR_W+1)'(i) < n_cmt)
        state_n[cmt_i + PTR_W'(i)] = S_CMT;
    end
    if (do_drain) state_n[head_i] = S_FREE;

    // commit is applied before flush so freshly committed stores survive
    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (state_n[j] == S_SPEC) state_n[j] = S_FREE;
      end
    end else if (do_alloc) begin
      state_n[tail_i] = S_SPEC;
    end

    head_n = head_q + (PTR_W+1)'(do_drain);
    cmt_n  = cmt_q + n_cmt;
    tail_n = flush ? cmt_n : tail_q + (PTR_W+1)'(do_alloc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) state_q[j] <= S_FREE;
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_n;
      head_q  <= head_n;
      cmt_q   <= cmt_n;
      tail_q  <= tail_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_alloc) begin
      addr_q[tail_i] <= alloc_addr;
      data_q[tail_i] <= alloc_data;
    end
  end

  // walk oldest to youngest from head so the last match is the youngest
  always_comb begin
    search_hit  = 1'b0;
    search_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[head_i + PTR_W'(i)] != S_FREE &&
          addr_q[head_i + PTR_W'(i)] == search_addr) begin
        search_hit  = 1'b1;
        search_data = data_q[head_i + PTR_W'(i)];
      end
    end
`ifdef STQ_ALLOC_BYPASS_EN
    if (alloc_valid && alloc_ready && !flush && !reset &&
        alloc_addr == search_addr) begin
      search_hit  = 1'b1;
      search_data = alloc_data;
    end
`else
`endif
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised successor to the fixed 8-entry, 16-bit store buffer.
- Circular queue of stores, written speculatively at dispatch and marked committed in program order by the ROB, up to COMMIT_W per cycle.
- Committed stores drain to data memory through a valid/ready handshake.
- Loads get combinational youngest-match forwarding.
- Flush discards only speculative (uncommitted) entries; committed entries survive and keep draining.

Parameters:
- DATA_W, 16, store data width
- ADDR_W, 16, store address width
- DEPTH, 8, entry count; power of two, >= 2
- COMMIT_W, 2, max stores committed per cycle; 1..DEPTH
- PTR_W, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all speculative entries
- alloc_valid  input  1  store presented for insertion
- alloc_addr  input  ADDR_W  store address
- alloc_data  input  DATA_W  store data
- alloc_ready  output  1  queue can accept a store this cycle
- commit_count  input  $clog2(COMMIT_W+1)  number of oldest speculative stores to commit
- search_addr  input  ADDR_W  load address to forward against
- search_hit  output  1  a live entry matches search_addr
- search_data  output  DATA_W  data of the youngest matching entry, 0 if none
- mem_valid  output  1  head entry is committed and offered to memory
- mem_addr  output  ADDR_W  head entry address
- mem_data  output  DATA_W  head entry data
- mem_ready  input  1  memory accepts the offered store
- occupancy  output  PTR_W+1  live entries (speculative plus committed)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state changes on the posedge of clk.
- Reset state:
  - Every entry FREE; head, cmt and tail pointers = 0; occupancy = 0.
  - alloc_ready = 1, mem_valid = 0, search_hit = 0, search_data = 0.
  - reset dominates flush, alloc and commit in the same cycle.
- Entry states: FREE -> SPEC (on alloc) -> COMMITTED (on commit) -> FREE (on drain, or SPEC -> FREE on flush).
- Pointers (PTR_W+1 bits, MSB = wrap bit):
  - head = oldest live entry; cmt = oldest SPEC entry; tail = next free slot.
  - Invariant: head <= cmt <= tail in circular order.
- Allocation:
  - alloc_ready = (occupancy != DEPTH), computed from registered state only.
  - No pass-through: a drain in the same cycle does not free a slot for an allocation while full.
  - Accepted when alloc_valid & alloc_ready: entry[tail] <= SPEC, tail += 1.
- Commit:
  - Marks min(commit_count, tail - cmt) entries starting at cmt as COMMITTED; cmt advances by that amount.
  - Excess count is clamped silently.
  - A store allocated in the same cycle cannot be committed that cycle.
- Drain:
  - mem_valid = entry[head] is COMMITTED; mem_addr/mem_data are driven combinationally from entry[head].
  - On mem_valid & mem_ready: entry FREE, head += 1.
  - Exactly one drain per cycle maximum.
  - While mem_valid = 1 and mem_ready = 0, mem_addr and mem_data stay stable.
- Flush (same cycle):
  - Commit is applied first, then every remaining SPEC entry goes FREE and tail <= new cmt.
  - An alloc in the flush cycle is dropped.
  - A drain in the flush cycle proceeds normally.
- Forwarding:
  - Combinational compare of search_addr against all live entries (SPEC or COMMITTED).
  - Youngest match wins, by age relative to tail, not by array index; correct across wrap-around.
  - No match: search_hit = 0, search_data = 0.
- occupancy = tail - head each cycle; it changes by +1 / -1 / 0 for alloc and drain; flush subtracts the discarded count.

Optional Feature:
- Macro: STQ_ALLOC_BYPASS_EN.
- Defined:
  - The accepted alloc in the current cycle also takes part in the forwarding search as the youngest entry.
  - alloc_addr == search_addr with alloc_valid & alloc_ready gives search_hit = 1, search_data = alloc_data the same cycle.
  - Not applied during flush or reset.
- Undefined: the new store becomes visible to search one cycle after acceptance.

Test Plan:
- Forwarding and commit: reset; alloc (0x0010, 0xAAAA), then (0x0010, 0xBBBB); search 0x0010 -> hit = 1, data = 0xBBBB, mem_valid = 0 until commit_count = 1; then mem_addr = 0x0010, mem_data = 0xAAAA.
- Full: with DEPTH = 8, alloc 8 stores, no commit -> alloc_ready = 0, occupancy = 8. A 9th alloc_valid is ignored. Commit 2 and drain 1 with mem_ready = 1 -> occupancy = 7, alloc_ready = 1 next cycle.
- Flush: alloc 5, commit 2, mem_ready = 0, then flush -> occupancy = 2, tail = cmt. Both committed stores drain in order once mem_ready = 1; a search for a discarded address -> hit = 0.
- Commit clamp and flush ordering: alloc 1, then commit_count = 2 with flush in the same cycle -> 1 entry committed and retained, occupancy = 1, no underflow.
- Wrap-around youngest match: cycle 12 stores through DEPTH = 8 with drains so the pointers wrap; two live stores to 0x0042 straddle index 7 -> 0; search returns the later store's data.
- Backpressure: hold mem_ready = 0 for 5 cycles -> mem_addr/mem_data stay stable; reset asserted mid-stall -> next cycle mem_valid = 0, occupancy = 0, alloc_ready = 1.
